// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master's transaction state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: converts a single-outstanding command/response handshake
// into one AXI-Lite write or read transaction, all outputs driven from registers.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STROBE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_data,
    input  logic [STROBE_WIDTH-1:0] i_cmd_strb,

    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic                    o_rsp_write,
    output logic [1:0]              o_rsp_resp,
    output logic [DATA_WIDTH-1:0]   o_rsp_data,

    output logic                    o_awvalid,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    input  logic                    i_awready,

    output logic                    o_wvalid,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [STROBE_WIDTH-1:0] o_wstrb,
    input  logic                    i_wready,

    input  logic                    i_bvalid,
    output logic                    o_bready,
    input  logic [1:0]              i_bresp,

    output logic                    o_arvalid,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    input  logic                    i_arready,

    input  logic                    i_rvalid,
    output logic                    o_rready,
    input  logic [1:0]              i_rresp,
    input  logic [DATA_WIDTH-1:0]   i_rdata
);

    state_e                  state_q,     state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    awvalid_q,   awvalid_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q,    awaddr_d;
    logic                    wvalid_q,    wvalid_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [STROBE_WIDTH-1:0] wstrb_q,     wstrb_d;
    logic                    aw_done_q,   aw_done_d;
    logic                    w_done_q,    w_done_d;
    logic                    bready_q,    bready_d;
    logic                    arvalid_q,   arvalid_d;
    logic [ADDR_WIDTH-1:0]   araddr_q,    araddr_d;
    logic                    rready_q,    rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_write_q, rsp_write_d;
    logic [1:0]              rsp_resp_q,  rsp_resp_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q,  rsp_data_d;

    logic aw_hs_c;
    logic w_hs_c;
    logic ar_hs_c;

    assign aw_hs_c = awvalid_q & i_awready;
    assign w_hs_c  = wvalid_q  & i_wready;
    assign ar_hs_c = arvalid_q & i_arready;

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            wvalid_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_resp_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            wvalid_q    <= wvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Next-state and next-output logic; every register holds unless a state acts on it.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        awaddr_d    = awaddr_q;
        wvalid_d    = wvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_data_d  = rsp_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (i_cmd_write) begin
                        awaddr_d  = i_cmd_addr;
                        wdata_d   = i_cmd_data;
                        wstrb_d   = i_cmd_strb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WR_REQ;
                    end else begin
                        araddr_d  = i_cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end

            // AW and W complete independently; B is only accepted once both have.
            ST_WR_REQ: begin
                if (aw_hs_c) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs_c) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs_c) && (w_done_q || w_hs_c)) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end

            ST_WR_RESP: begin
                if (i_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_resp_d  = i_bresp;
                    rsp_data_d  = '0;
                    state_d     = ST_RSP;
                end
            end

            ST_RD_ADDR: begin
                if (ar_hs_c) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                if (i_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_resp_d  = i_rresp;
                    rsp_data_d  = i_rdata;
                    state_d     = ST_RSP;
                end
            end

            ST_RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_awvalid   = awvalid_q;
    assign o_awaddr    = awaddr_q;
    assign o_wvalid    = wvalid_q;
    assign o_wdata     = wdata_q;
    assign o_wstrb     = wstrb_q;
    assign o_bready    = bready_q;
    assign o_arvalid   = arvalid_q;
    assign o_araddr    = araddr_q;
    assign o_rready    = rready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_write = rsp_write_q;
    assign o_rsp_resp  = rsp_resp_q;
    assign o_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: an AXI-Lite slave model with configurable
// channel delays plus a response scoreboard fed by the command driver.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    typedef struct packed {
        logic          write;
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cmd_valid, o_cmd_ready, i_cmd_write;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_data;
    logic [SW-1:0] i_cmd_strb;
    logic          o_rsp_valid, i_rsp_ready, o_rsp_write;
    logic [1:0]    o_rsp_resp;
    logic [DW-1:0] o_rsp_data;
    logic          o_awvalid, i_awready;
    logic [AW-1:0] o_awaddr;
    logic          o_wvalid, i_wready;
    logic [DW-1:0] o_wdata;
    logic [SW-1:0] o_wstrb;
    logic          i_bvalid, o_bready;
    logic [1:0]    i_bresp;
    logic          o_arvalid, i_arready;
    logic [AW-1:0] o_araddr;
    logic          i_rvalid, o_rready;
    logic [1:0]    i_rresp;
    logic [DW-1:0] i_rdata;

    axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_strb(i_cmd_strb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
        .o_rsp_resp(o_rsp_resp), .o_rsp_data(o_rsp_data),
        .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .i_awready(i_awready),
        .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .i_wready(i_wready),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
        .o_arvalid(o_arvalid), .o_araddr(o_araddr), .i_arready(i_arready),
        .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rresp(i_rresp), .i_rdata(i_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Slave model configuration (written by tests only)
    int         aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0] bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
    logic       bvalid_force = 1'b0;

    // Slave model state and observations (written by the model only)
    int            aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic          aw_seen, w_seen, b_req, r_req;
    logic [AW-1:0] last_awaddr, last_araddr;
    logic [DW-1:0] last_wdata;
    logic [SW-1:0] last_wstrb;
    int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0, rsp_n = 0;
    int aw_hi = 0, w_hi = 0, b_early_n = 0, proto_err = 0;
    int w_hs_cyc = 0, b_hs_cyc = 0, accept_cyc = 0, rsp_rise_cyc = 0;
    logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic          p_awvalid, p_aw_hs, p_wvalid, p_w_hs, p_arvalid, p_ar_hs;
    logic          p_bready, p_b_hs, p_rready, p_r_hs, p_rsp_valid;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;
    logic [SW-1:0] p_wstrb;
    logic [DW-1:0] mem [logic [AW-1:0]];
    rsp_t          obs_arr [64];

    rsp_t exp_q[$];
    int   rd_idx = 0;

    function automatic logic [DW-1:0] strb_mask(input logic [SW-1:0] s);
        logic [DW-1:0] m = '0;
        for (int b = 0; b < int'(SW); b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Slave responder and protocol monitor, evaluated on the falling edge
    initial forever begin
        @(negedge clk);
        if (rst) begin
            {i_awready, i_wready, i_bvalid, i_arready, i_rvalid} = '0;
            i_bresp = '0; i_rresp = '0; i_rdata = '0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
            {aw_seen, w_seen, b_req, r_req} = '0;
            {p_awvalid, p_aw_hs, p_wvalid, p_w_hs, p_arvalid, p_ar_hs} = '0;
            {p_bready, p_b_hs, p_rready, p_r_hs, p_rsp_valid} = '0;
        end else begin
            if (p_awvalid && !p_aw_hs && (!o_awvalid || o_awaddr !== p_awaddr)) proto_err++;
            if (p_wvalid && !p_w_hs && (!o_wvalid || o_wdata !== p_wdata || o_wstrb !== p_wstrb)) proto_err++;
            if (p_arvalid && !p_ar_hs && (!o_arvalid || o_araddr !== p_araddr)) proto_err++;
            if ((p_aw_hs && o_awvalid) || (p_w_hs && o_wvalid) || (p_ar_hs && o_arvalid)) proto_err++;
            if ((p_bready && !p_b_hs && !o_bready) || (p_rready && !p_r_hs && !o_rready)) proto_err++;
            if (o_bready && !(aw_seen && w_seen)) proto_err++;

            i_awready = o_awvalid && (aw_cnt >= aw_delay);
            i_wready  = o_wvalid  && (w_cnt >= w_delay);
            i_arready = o_arvalid && (ar_cnt >= ar_delay);
            i_bvalid  = b_req || (bvalid_force && (aw_seen || w_seen || o_awvalid || o_wvalid));
            i_bresp   = i_bvalid ? bresp_cfg : 2'b00;
            i_rvalid  = r_req && (r_cnt >= r_delay);
            i_rresp   = i_rvalid ? rresp_cfg : 2'b00;
            i_rdata   = (i_rvalid && mem.exists(last_araddr)) ? mem[last_araddr] : '0;

            aw_hs = o_awvalid && i_awready;
            w_hs  = o_wvalid && i_wready;
            b_hs  = i_bvalid && o_bready;
            ar_hs = o_arvalid && i_arready;
            r_hs  = i_rvalid && o_rready;

            if (i_bvalid && !o_bready) b_early_n++;
            if (b_hs) begin
                b_hs_n++;
                b_hs_cyc = cyc;
                mem[last_awaddr] = ((mem.exists(last_awaddr) ? mem[last_awaddr] : '0)
                                    & ~strb_mask(last_wstrb)) | (last_wdata & strb_mask(last_wstrb));
                {aw_seen, w_seen, b_req} = '0;
            end
            if (o_awvalid) aw_hi++;
            if (aw_hs) begin
                aw_hs_n++; last_awaddr = o_awaddr; aw_seen = 1'b1; aw_cnt = 0;
            end else if (o_awvalid) aw_cnt++;
            if (o_wvalid) w_hi++;
            if (w_hs) begin
                w_hs_n++; w_hs_cyc = cyc; last_wdata = o_wdata; last_wstrb = o_wstrb;
                w_seen = 1'b1; w_cnt = 0;
            end else if (o_wvalid) w_cnt++;
            if (aw_seen && w_seen && !b_hs) b_req = 1'b1;

            if (r_hs) begin
                r_hs_n++; r_req = 1'b0;
            end else if (r_req && !i_rvalid) r_cnt++;
            if (ar_hs) begin
                ar_hs_n++; last_araddr = o_araddr; r_req = 1'b1; r_cnt = 0; ar_cnt = 0;
            end else if (o_arvalid) ar_cnt++;

            if (i_cmd_valid && o_cmd_ready) accept_cyc = cyc;
            if (o_rsp_valid && !p_rsp_valid) rsp_rise_cyc = cyc;
            if (o_rsp_valid && i_rsp_ready) begin
                if (rsp_n < 64) obs_arr[rsp_n] = {o_rsp_write, o_rsp_resp, o_rsp_data};
                rsp_n++;
            end

            p_awvalid = o_awvalid; p_aw_hs = aw_hs; p_awaddr = o_awaddr;
            p_wvalid = o_wvalid; p_w_hs = w_hs; p_wdata = o_wdata; p_wstrb = o_wstrb;
            p_arvalid = o_arvalid; p_ar_hs = ar_hs; p_araddr = o_araddr;
            p_bready = o_bready; p_b_hs = b_hs; p_rready = o_rready; p_r_hs = r_hs;
            p_rsp_valid = o_rsp_valid;
        end
    end

    // Issue one command; the expected response is queued at the accepting edge.
    task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, input logic expect_rsp,
                          input logic [1:0] eresp, input logic [DW-1:0] edata);
        int n = 0;
        i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_addr = addr;
        i_cmd_data = data; i_cmd_strb = strb;
        while (!o_cmd_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!o_cmd_ready) begin
            $display("FAIL cmd_ready_timeout got=0 exp=1");
            $fatal(1, "command never accepted");
        end
        @(posedge clk);
        if (expect_rsp) exp_q.push_back({wr, eresp, edata});
        #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, output bit ok);
        int n = 0;
        while (rsp_n < target && n < 300) begin
            @(posedge clk); n++;
        end
        #1;
        ok = (rsp_n >= target);
    endtask

    task automatic test_reset;
        logic [9:0]   ctrl;
        logic [131:0] dp;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        ctrl = {o_cmd_ready, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready,
                o_rsp_valid, o_rsp_write, o_rsp_resp};
        dp = {o_awaddr, o_wdata, o_wstrb, o_araddr, o_rsp_data};
        checks++;
        if (ctrl !== 10'b10_0000_0000) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 10'b10_0000_0000);
        end
        checks++;
        if (dp !== '0) begin
            failures++; $display("FAIL reset_datapath got=%h exp=0", dp);
        end
    endtask

    task automatic test_write_basic;
        int aw0 = aw_hs_n, w0 = w_hs_n, r0 = rsp_n;
        bit ok;
        rsp_t e, g;
        do_cmd(1'b1, 32'h0, 32'hDEADBEEF, 4'hF, 1'b1, RESP_OKAY, 32'h0);
        wait_rsp(r0 + 1, ok);
        repeat (3) @(posedge clk);
        #1;
        e = exp_q.pop_front(); g = obs_arr[rd_idx]; rd_idx++;
        checks++;
        if (!ok || g !== e) begin failures++; $display("FAIL wr_basic_rsp got=%h exp=%h ok=%0d", g, e, ok); end
        checks++;
        if (aw_hs_n - aw0 != 1 || w_hs_n - w0 != 1) begin
            failures++; $display("FAIL wr_basic_hs_count got aw=%0d w=%0d exp 1/1", aw_hs_n - aw0, w_hs_n - w0);
        end
        checks++;
        if (last_awaddr !== 32'h0) begin failures++; $display("FAIL wr_basic_awaddr got=%h exp=0", last_awaddr); end
        checks++;
        if ({last_wdata, last_wstrb} !== {32'hDEADBEEF, 4'hF}) begin
            failures++; $display("FAIL wr_basic_wdata got=%h/%h exp=deadbeef/f", last_wdata, last_wstrb);
        end
        checks++;
        if (rsp_rise_cyc - accept_cyc != 3) begin
            failures++; $display("FAIL wr_basic_latency got=%0d exp=3", rsp_rise_cyc - accept_cyc);
        end
    endtask

    task automatic test_write_wdelay;
        int awh0 = aw_hi, wh0 = w_hi, pe0 = proto_err, r0 = rsp_n;
        bit ok;
        rsp_t e, g;
        w_delay = 3;
        do_cmd(1'b1, 32'h1, 32'h12345678, 4'hF, 1'b1, RESP_OKAY, 32'h0);
        wait_rsp(r0 + 1, ok);
        w_delay = 0;
        e = exp_q.pop_front(); g = obs_arr[rd_idx]; rd_idx++;
        checks++;
        if (!ok || g !== e) begin failures++; $display("FAIL wr_wdelay_rsp got=%h exp=%h ok=%0d", g, e, ok); end
        checks++;
        if (aw_hi - awh0 != 1) begin failures++; $display("FAIL wr_wdelay_awvalid_cycles got=%0d exp=1", aw_hi - awh0); end
        checks++;
        if (w_hi - wh0 != 4) begin failures++; $display("FAIL wr_wdelay_wvalid_cycles got=%0d exp=4", w_hi - wh0); end
        checks++;
        if (b_hs_cyc != w_hs_cyc + 1) begin
            failures++; $display("FAIL wr_wdelay_b_after_w got b=%0d w=%0d exp b=w+1", b_hs_cyc, w_hs_cyc);
        end
        checks++;
        if (rsp_rise_cyc - accept_cyc != 6) begin
            failures++; $display("FAIL wr_wdelay_latency got=%0d exp=6", rsp_rise_cyc - accept_cyc);
        end
        checks++;
        if (proto_err != pe0) begin failures++; $display("FAIL wr_wdelay_protocol got=%0d exp=0", proto_err - pe0); end
    endtask

    task automatic test_read_delay;
        int r0 = rsp_n;
        bit ok;
        rsp_t e, g;
        r_delay = 2;
        do_cmd(1'b0, 32'h1, 32'h0, 4'h0, 1'b1, RESP_OKAY, 32'h12345678);
        wait_rsp(r0 + 1, ok);
        r_delay = 0;
        e = exp_q.pop_front(); g = obs_arr[rd_idx]; rd_idx++;
        checks++;
        if (!ok || g !== e) begin failures++; $display("FAIL rd_delay_rsp got=%h exp=%h ok=%0d", g, e, ok); end
        checks++;
        if (last_araddr !== 32'h1) begin failures++; $display("FAIL rd_delay_araddr got=%h exp=1", last_araddr); end
        checks++;
        if (rsp_rise_cyc - accept_cyc != 5) begin
            failures++; $display("FAIL rd_delay_latency got=%0d exp=5", rsp_rise_cyc - accept_cyc);
        end
    endtask

    task automatic test_read_error_hold;
        int r0 = rsp_n, n = 0;
        bit ok;
        rsp_t e, g;
        rresp_cfg = RESP_SLVERR;
        i_rsp_ready = 1'b0;
        do_cmd(1'b0, 32'h5, 32'h0, 4'h0, 1'b1, RESP_SLVERR, 32'h0);
        while (!o_rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (o_rsp_valid !== 1'b1 || rsp_n != r0) begin
                failures++; $display("FAIL rd_err_hold[%0d] got valid=%b rsps=%0d exp valid=1 rsps=%0d", i, o_rsp_valid, rsp_n - r0, 0);
            end
        end
        i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin
            failures++; $display("FAIL rd_err_release got valid/ready=%b exp=01", {o_rsp_valid, o_cmd_ready});
        end
        wait_rsp(r0 + 1, ok);
        rresp_cfg = RESP_OKAY;
        e = exp_q.pop_front(); g = obs_arr[rd_idx]; rd_idx++;
        checks++;
        if (!ok || g !== e) begin failures++; $display("FAIL rd_err_rsp got=%h exp=%h ok=%0d", g, e, ok); end
    endtask

    task automatic test_reset_abort;
        int r0 = rsp_n, n = 0;
        bit ok;
        rsp_t e, g;
        r_delay = 20;
        do_cmd(1'b0, 32'h8, 32'h0, 4'h0, 1'b0, RESP_OKAY, 32'h0);
        while (o_rready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (o_rready !== 1'b1) begin failures++; $display("FAIL abort_reach_rd_data got rready=%b exp=1", o_rready); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        r_delay = 0;
        checks++;
        if ({o_arvalid, o_rready, o_rsp_valid, o_cmd_ready} !== 4'b0001) begin
            failures++; $display("FAIL abort_outputs got=%b exp=0001", {o_arvalid, o_rready, o_rsp_valid, o_cmd_ready});
        end
        do_cmd(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 1'b1, RESP_OKAY, 32'h0);
        wait_rsp(r0 + 1, ok);
        repeat (3) @(posedge clk);
        #1;
        e = exp_q.pop_front(); g = obs_arr[rd_idx]; rd_idx++;
        checks++;
        if (!ok || g !== e) begin failures++; $display("FAIL abort_next_write_rsp got=%h exp=%h ok=%0d", g, e, ok); end
        checks++;
        if (rsp_n - r0 != 1) begin failures++; $display("FAIL abort_rsp_count got=%0d exp=1", rsp_n - r0); end
    endtask

    task automatic test_early_bvalid;
        int b0 = b_hs_n, r0 = rsp_n, be0 = b_early_n, pe0 = proto_err;
        bit ok;
        rsp_t e, g;
        bvalid_force = 1'b1;
        w_delay = 3;
        do_cmd(1'b1, 32'h40, 32'h0BADC0DE, 4'hF, 1'b1, RESP_OKAY, 32'h0);
        wait_rsp(r0 + 1, ok);
        repeat (4) @(posedge clk);
        #1;
        bvalid_force = 1'b0;
        w_delay = 0;
        e = exp_q.pop_front(); g = obs_arr[rd_idx]; rd_idx++;
        checks++;
        if (!ok || g !== e) begin failures++; $display("FAIL early_b_rsp got=%h exp=%h ok=%0d", g, e, ok); end
        checks++;
        if (b_early_n == be0) begin failures++; $display("FAIL early_b_stimulus got=0 early bvalid cycles exp>0"); end
        checks++;
        if (b_hs_n - b0 != 1 || rsp_n - r0 != 1) begin
            failures++; $display("FAIL early_b_counts got b=%0d rsp=%0d exp 1/1", b_hs_n - b0, rsp_n - r0);
        end
        checks++;
        if (b_hs_cyc != w_hs_cyc + 1) begin
            failures++; $display("FAIL early_b_order got b=%0d w=%0d exp b=w+1", b_hs_cyc, w_hs_cyc);
        end
        checks++;
        if (proto_err != pe0) begin failures++; $display("FAIL early_b_protocol got=%0d exp=0", proto_err - pe0); end
    endtask

    task automatic test_back_to_back;
        int r0 = rsp_n;
        bit ok;
        rsp_t e, g;
        do_cmd(1'b1, 32'h20, 32'hAABBCCDD, 4'h3, 1'b1, RESP_OKAY, 32'h0);
        wait_rsp(r0 + 1, ok);
        e = exp_q.pop_front(); g = obs_arr[rd_idx]; rd_idx++;
        checks++;
        if (!ok || g !== e || last_wstrb !== 4'h3) begin
            failures++; $display("FAIL b2b_strb_write got=%h strb=%h exp=%h strb=3", g, last_wstrb, e);
        end
        do_cmd(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, RESP_OKAY, 32'h0000CCDD);
        wait_rsp(r0 + 2, ok);
        e = exp_q.pop_front(); g = obs_arr[rd_idx]; rd_idx++;
        checks++;
        if (!ok || g !== e) begin failures++; $display("FAIL b2b_readback got=%h exp=%h ok=%0d", g, e, ok); end
        bresp_cfg = RESP_DECERR;
        do_cmd(1'b1, 32'h30, 32'h55AA55AA, 4'hF, 1'b1, RESP_DECERR, 32'h0);
        wait_rsp(r0 + 3, ok);
        bresp_cfg = RESP_OKAY;
        e = exp_q.pop_front(); g = obs_arr[rd_idx]; rd_idx++;
        checks++;
        if (!ok || g !== e) begin failures++; $display("FAIL b2b_decerr_write got=%h exp=%h ok=%0d", g, e, ok); end
    endtask

    initial begin
        rst = 1'b1;
        i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0;
        i_cmd_data = '0; i_cmd_strb = '0; i_rsp_ready = 1'b1;
        test_reset();
        test_write_basic();
        test_write_wdelay();
        test_read_delay();
        test_read_error_hold();
        test_reset_abort();
        test_early_bvalid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
AXI4-Lite master that turns a simple single-outstanding command/response interface into AXI-Lite write or read transactions. It is the initiator counterpart to the team's AXI-Lite slave register bridge. Bench and SoC logic use it to drive register-mapped peripherals. There is one transaction in flight at a time, and no reordering.

Parameters:
ADDR_WIDTH, 32, width of the AXI and command address.
DATA_WIDTH, 32, width of the AXI and command data.
STROBE_WIDTH, DATA_WIDTH/8, number of write strobe bits.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
i_cmd_valid  in  1  command request.
o_cmd_ready  out  1  command accepted when valid && ready.
i_cmd_write  in  1  1 selects write, 0 selects read.
i_cmd_addr  in  ADDR_WIDTH  target address.
i_cmd_data  in  DATA_WIDTH  write data.
i_cmd_strb  in  STROBE_WIDTH  write byte enables.
o_rsp_valid  out  1  response available.
i_rsp_ready  in  1  response consumed.
o_rsp_write  out  1  response belongs to a write.
o_rsp_resp  out  2  BRESP or RRESP value.
o_rsp_data  out  DATA_WIDTH  RDATA; 0 for writes.
o_awvalid/o_awaddr/i_awready  out/out/in  1/ADDR_WIDTH/1  write address channel.
o_wvalid/o_wdata/o_wstrb/i_wready  out/out/out/in  1/DATA_WIDTH/STROBE_WIDTH/1  write data channel.
i_bvalid/o_bready/i_bresp  in/out/in  1/1/2  write response channel.
o_arvalid/o_araddr/i_arready  out/out/in  1/ADDR_WIDTH/1  read address channel.
i_rvalid/o_rready/i_rresp/i_rdata  in/out/in/in  1/1/2/DATA_WIDTH  read data channel.

Behaviour:
- Reset values: all valid and ready outputs are 0, except o_cmd_ready = 1. All data, address, resp and strobe outputs are 0. The FSM is in IDLE.
- A reset during any state aborts the transaction. Next cycle all outputs hold their reset values; no response is issued.
- All outputs are registered, and the FSM has the states below.
- IDLE:
  - o_cmd_ready = 1.
  - On accept, latch addr, data and strb.
  - Write: go to WR_REQ and assert o_awvalid and o_wvalid in the next cycle.
  - Read: go to RD_ADDR and assert o_arvalid in the next cycle.
- WR_REQ:
  - AW and W are driven together and tracked independently with aw_done and w_done flags.
  - Each valid drops in the cycle after its own handshake.
  - If both handshakes land in the same cycle, both drop together.
  - Once both flags are set, go to WR_RESP with o_bready = 1.
- WR_RESP:
  - On i_bvalid && o_bready, capture i_bresp, drop o_bready and go to RSP.
  - A bvalid that arrives before both AW and W have completed is ignored, because o_bready is 0.
- RD_ADDR: on the arvalid && arready handshake, drop o_arvalid, assert o_rready and go to RD_DATA.
- RD_DATA: on rvalid && rready, capture i_rdata and i_rresp, drop o_rready and go to RSP.
- RSP:
  - o_rsp_valid = 1, with payload stable until i_rsp_ready.
  - On handshake, go to IDLE with o_cmd_ready = 1 in the next cycle.
  - No back-to-back commands within the same cycle.
- Valid outputs never drop before their handshake, and address, data and strb stay stable while valid is asserted.
- Minimum latency with zero-wait responders:
  - Write: accept at N, AW and W at N+1, B at N+2, rsp_valid at N+3.
  - Read: accept at N, AR at N+1, R at N+2, rsp_valid at N+3.
- o_rsp_data is forced to 0 for writes.
- There is no timeout; a hung slave stalls the block indefinitely.

Decomposition:
- Shared package axi_lite_pkg holds:
  - AXI response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - The FSM state encoding (IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, RSP).
- The block is a single module; no sub-module is needed.

Test Plan:
- After rst, write addr 0x0, data 0xDEADBEEF, strb 0xF, with awready=wready=bvalid=1 and bresp=00: exactly one AW and one W handshake carry those values, then rsp_valid with write=1, resp=00 and data=0.
- Write addr 0x1, data 0x12345678, with wready delayed 3 cycles after awready: o_awvalid drops after its handshake, o_wvalid is held until wready, o_bready rises only after W completes, and resp=00.
- Read addr 0x1 after the previous write, with the responder returning 0x12345678 after arready plus 2 cycles of rvalid delay: rsp data=0x12345678 and resp=00.
- Read addr 0x5 with the responder returning rresp=10 and rdata=0: rsp resp=10 and data=0; rsp_valid is held while i_rsp_ready=0 for 4 cycles, then clears on the handshake.
- Issue a read and assert rst while in RD_DATA: the next cycle has arvalid=rready=rsp_valid=0 and cmd_ready=1, and a new write completes normally afterwards.
- Apply i_bvalid=1 before wready: no B handshake occurs until W completes, and exactly one response is reported.
